// File: rtl/cic3_pkg.sv
// rtl/cic3_pkg.sv - shared widths, limits and decimation decode for the third-stage CIC
package cic3_pkg;

    localparam int IN_W     = 16;
    localparam int OUT_W    = 28;
    localparam int N_STAGES = 3;
    localparam int MAX_SEL  = 4;
    localparam int SEL_W    = 3;
    localparam int CNT_W    = 4;

    // Q1.15 output range; anything outside is flagged but still delivered
    localparam logic signed [OUT_W-1:0] RANGE_MAX = OUT_W'(32767);
    localparam logic signed [OUT_W-1:0] RANGE_MIN = OUT_W'(-32768);

    // Decimation factor D = 2^sel
    function automatic logic [4:0] sel_to_d(input logic [SEL_W-1:0] sel);
        return 5'd1 << sel;
    endfunction

    // CIC DC gain is D^N = 2^(N*sel), so unity gain needs a right shift of N*sel
    function automatic logic [3:0] sel_to_shift(input logic [SEL_W-1:0] sel);
        return 4'(N_STAGES * int'(sel));
    endfunction

endpackage

// File: rtl/cic3_comp_fir.sv
// rtl/cic3_comp_fir.sv - 3-tap inverse-sinc compensator (-1/8, 5/4, -1/8) with bypass
module cic3_comp_fir
    import cic3_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_enable,
    input  logic                    clear,
    input  logic                    bypass,
    input  logic signed [OUT_W-1:0] s_tdata,
    input  logic                    s_tvalid,
    output logic signed [OUT_W-1:0] m_tdata,
    output logic                    m_tvalid
);

    // Headroom for 10x the centre tap before the divide by 8
    localparam int ACC_W = OUT_W + 4;

    logic signed [OUT_W-1:0] tap1;
    logic signed [OUT_W-1:0] tap2;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_nx;
    logic signed [ACC_W-1:0] tap1_w;
    logic                    acc_valid;

    assign tap1_w = ACC_W'(tap1);
    // 10*c[n-1] - c[n] - c[n-2], with 10x built from shifts
    assign acc_nx = (tap1_w <<< 3) + (tap1_w <<< 1) - ACC_W'(s_tdata) - ACC_W'(tap2);

    // Tap line and accumulator advance only on decimated samples; output stage muxes bypass
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tap1      <= '0;
            tap2      <= '0;
            acc       <= '0;
            acc_valid <= 1'b0;
            m_tdata   <= '0;
            m_tvalid  <= 1'b0;
        end else if (clk_enable) begin
            if (clear) begin
                tap1      <= '0;
                tap2      <= '0;
                acc       <= '0;
                acc_valid <= 1'b0;
                m_tdata   <= '0;
                m_tvalid  <= 1'b0;
            end else begin
                acc_valid <= s_tvalid;
                if (s_tvalid) begin
                    acc  <= acc_nx;
                    tap1 <= s_tdata;
                    tap2 <= tap1;
                end
                if (bypass) begin
                    m_tvalid <= s_tvalid;
                    if (s_tvalid) begin
                        m_tdata <= s_tdata;
                    end
                end else begin
                    m_tvalid <= acc_valid;
                    if (acc_valid) begin
                        m_tdata <= OUT_W'(acc >>> 3);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/cic_third_stage_top.sv
// rtl/cic_third_stage_top.sv - 3-stage CIC decimator, D = 1..16, unity gain, optional compensation
module cic_third_stage_top
    import cic3_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_enable,
    input  logic signed [IN_W-1:0]  x_in,
    input  logic                    x_valid,
    input  logic                    ctrl_enable,
    input  logic                    ctrl_reset,
    input  logic [7:0]              ctrl_decim_sel,
    input  logic                    ctrl_comp_enable,
    output logic                    ce_out,
    output logic signed [OUT_W-1:0] y_out,
    output logic                    y_valid,
    output logic [7:0]              status_D_active,
    output logic [7:0]              status_overflow,
    output logic                    status_ready
);

    logic [SEL_W-1:0] sel_reg;
    logic             comp_reg;
    logic [SEL_W-1:0] sel_eff;
    logic             sel_illegal;
    logic             cfg_change;
    logic             clear;
    logic             accept;
    logic [CNT_W-1:0] d_minus1;
    logic [3:0]       shift_amt;
    logic [4:0]       unused_sel_bits;

    logic signed [IN_W-1:0]  x_reg;
    logic                    v0;
    logic signed [OUT_W-1:0] int1, int2, int3;
    logic signed [OUT_W-1:0] int1_nx, int2_nx, int3_nx;
    logic [CNT_W-1:0]        cnt;
    logic                    v1;
    logic signed [OUT_W-1:0] dly1, dly2, dly3;
    logic signed [OUT_W-1:0] c1, c2, c3;
    logic signed [OUT_W-1:0] comb_reg;
    logic                    v2;
    logic signed [OUT_W-1:0] scaled;
    logic                    v3;
    logic signed [OUT_W-1:0] fir_data;
    logic                    fir_valid;
    logic                    ovf_range;
    logic                    ovf_sel;

    // Only sel[2:0] is decoded; the upper bits are deliberately ignored
    assign unused_sel_bits = ctrl_decim_sel[7:3];
    assign sel_illegal     = ctrl_decim_sel[2:0] > SEL_W'(MAX_SEL);
    assign sel_eff         = sel_illegal ? SEL_W'(MAX_SEL) : ctrl_decim_sel[2:0];
    assign cfg_change      = (sel_eff != sel_reg) || (ctrl_comp_enable != comp_reg);
    // A config change flushes the datapath on the same edge the new config is latched
    assign clear           = ctrl_reset || cfg_change;
    assign accept          = ctrl_enable && x_valid && !clear;

    assign d_minus1        = CNT_W'(sel_to_d(sel_reg) - 5'd1);
    assign shift_amt       = sel_to_shift(sel_reg);
    assign status_D_active = {3'b000, sel_to_d(sel_reg)};
    assign status_overflow = {6'b000000, ovf_sel, ovf_range};
    assign ce_out          = v1;

    // Integrator cascade: each stage sees the freshly updated stage before it
    assign int1_nx = int1 + {{(OUT_W-IN_W){x_reg[IN_W-1]}}, x_reg};
    assign int2_nx = int2 + int1_nx;
    assign int3_nx = int3 + int2_nx;

    // Comb cascade (differential delay 1) evaluated at the decimated rate
    assign c1 = int3 - dly1;
    assign c2 = c1 - dly2;
    assign c3 = c2 - dly3;

    // Effective configuration register; keeps sampling through ctrl_reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_reg  <= '0;
            comp_reg <= 1'b0;
        end else if (clk_enable) begin
            sel_reg  <= sel_eff;
            comp_reg <= ctrl_comp_enable;
        end
    end

    // CIC pipeline: input register, integrators + window counter, combs, gain shift
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_reg    <= '0;
            v0       <= 1'b0;
            int1     <= '0;
            int2     <= '0;
            int3     <= '0;
            cnt      <= '0;
            v1       <= 1'b0;
            dly1     <= '0;
            dly2     <= '0;
            dly3     <= '0;
            comb_reg <= '0;
            v2       <= 1'b0;
            scaled   <= '0;
            v3       <= 1'b0;
        end else if (clk_enable) begin
            if (clear) begin
                x_reg    <= '0;
                v0       <= 1'b0;
                int1     <= '0;
                int2     <= '0;
                int3     <= '0;
                cnt      <= '0;
                v1       <= 1'b0;
                dly1     <= '0;
                dly2     <= '0;
                dly3     <= '0;
                comb_reg <= '0;
                v2       <= 1'b0;
                scaled   <= '0;
                v3       <= 1'b0;
            end else begin
                v0 <= accept;
                if (accept) begin
                    x_reg <= x_in;
                end
                v1 <= 1'b0;
                if (v0) begin
                    int1 <= int1_nx;
                    int2 <= int2_nx;
                    int3 <= int3_nx;
                    cnt  <= (cnt == d_minus1) ? '0 : cnt + CNT_W'(1);
                    v1   <= (cnt == d_minus1);
                end
                v2 <= v1;
                if (v1) begin
                    dly1     <= int3;
                    dly2     <= c1;
                    dly3     <= c2;
                    comb_reg <= c3;
                end
                v3 <= v2;
                if (v2) begin
                    scaled <= comb_reg >>> shift_amt;
                end
            end
        end
    end

    cic3_comp_fir u_comp_fir (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .clear      (clear),
        .bypass     (!comp_reg),
        .s_tdata    (scaled),
        .s_tvalid   (v3),
        .m_tdata    (fir_data),
        .m_tvalid   (fir_valid)
    );

    // Output register and ready tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_out        <= '0;
            y_valid      <= 1'b0;
            status_ready <= 1'b0;
        end else if (clk_enable) begin
            if (clear) begin
                y_out   <= '0;
                y_valid <= 1'b0;
            end else begin
                y_valid <= fir_valid;
                if (fir_valid) begin
                    y_out <= fir_data;
                end
            end
            if (clear || !ctrl_enable) begin
                status_ready <= 1'b0;
            end else if (fir_valid) begin
                status_ready <= 1'b1;
            end
        end
    end

    // Sticky flags survive reconfiguration flushes; only ctrl_reset clears them
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_range <= 1'b0;
            ovf_sel   <= 1'b0;
        end else if (clk_enable) begin
            if (ctrl_reset) begin
                ovf_range <= 1'b0;
                ovf_sel   <= 1'b0;
            end else begin
                if (sel_illegal) begin
                    ovf_sel <= 1'b1;
                end
                if (fir_valid && ((fir_data > RANGE_MAX) || (fir_data < RANGE_MIN))) begin
                    ovf_range <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cic_third_stage_top.sv
// tb/tb_cic_third_stage_top.sv - directed self-checking bench for cic_third_stage_top
module tb_cic_third_stage_top;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               clk_enable = 1'b0;
    logic signed [15:0] x_in = '0;
    logic               x_valid = 1'b0;
    logic               ctrl_enable = 1'b0;
    logic               ctrl_reset = 1'b0;
    logic [7:0]         ctrl_decim_sel = '0;
    logic               ctrl_comp_enable = 1'b0;
    logic               ce_out;
    logic signed [27:0] y_out;
    logic               y_valid;
    logic [7:0]         status_D_active;
    logic [7:0]         status_overflow;
    logic               status_ready;

    int                 tests_run = 0;
    int                 tests_failed = 0;
    int                 cyc = 0;
    int                 yv_count = 0;
    int                 ce_count = 0;
    int                 bad_int = 0;
    int                 last_v_cyc = -1;
    int                 exp_period = 0;
    longint             max_y = 0;
    longint             last_y = 0;

    cic_third_stage_top dut (
        .clk              (clk),
        .reset            (rst_n),
        .clk_enable       (clk_enable),
        .x_in             (x_in),
        .x_valid          (x_valid),
        .ctrl_enable      (ctrl_enable),
        .ctrl_reset       (ctrl_reset),
        .ctrl_decim_sel   (ctrl_decim_sel),
        .ctrl_comp_enable (ctrl_comp_enable),
        .ce_out           (ce_out),
        .y_out            (y_out),
        .y_valid          (y_valid),
        .status_D_active  (status_D_active),
        .status_overflow  (status_overflow),
        .status_ready     (status_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and sample outputs 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (ce_out) ce_count++;
        if (y_valid) begin
            if (last_v_cyc >= 0 && exp_period > 0 && (cyc - last_v_cyc) != exp_period) bad_int++;
            last_v_cyc = cyc;
            yv_count++;
            last_y = y_out;
            if (y_out > max_y) max_y = y_out;
        end
    endtask

    task automatic clear_stats(input int period);
        yv_count   = 0;
        ce_count   = 0;
        bad_int    = 0;
        last_v_cyc = -1;
        exp_period = period;
        max_y      = -(64'sd1 <<< 40);
    endtask

    task automatic configure(input int sel, input logic comp);
        x_valid          = 1'b0;
        ctrl_decim_sel   = 8'(sel);
        ctrl_comp_enable = comp;
        tick();
        tick();
    endtask

    // kind 0: constant val; kind 1: ramp (i%64-32)*256
    task automatic feed(input int n, input int kind, input int val);
        for (int i = 0; i < n; i++) begin
            x_valid = 1'b1;
            x_in    = (kind == 0) ? 16'(val) : 16'(((i % 64) - 32) * 256);
            tick();
        end
        x_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        x_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_y_out", y_out, 0);
        check_eq("rst_y_valid", y_valid, 0);
        check_eq("rst_ce_out", ce_out, 0);
        check_eq("rst_overflow", status_overflow, 0);
        check_eq("rst_ready", status_ready, 0);
        check_eq("rst_d_active", status_D_active, 1);

        rst_n       = 1'b1;
        clk_enable  = 1'b1;
        ctrl_enable = 1'b1;
        tick();

        // D=1 impulse: sample accepted at tick 3 appears at tick 8
        clear_stats(1);
        for (int j = 0; j < 14; j++) begin
            x_valid = 1'b1;
            x_in    = (j == 3) ? 16'sd1 : 16'sd0;
            tick();
            check_eq($sformatf("imp_valid_%0d", j), y_valid, (j >= 5) ? 1 : 0);
            check_eq($sformatf("imp_y_%0d", j), y_out, (j == 8) ? 1 : 0);
        end
        drain(6);
        check_eq("imp_ready", status_ready, 1);

        // D=4 DC
        configure(2, 1'b0);
        check_eq("d4_d_active", status_D_active, 4);
        check_eq("d4_ready_low", status_ready, 0);
        clear_stats(4);
        feed(64, 0, 8192);
        drain(8);
        check_eq("d4_count", yv_count, 16);
        check_eq("d4_ce_count", ce_count, 16);
        check_eq("d4_period", bad_int, 0);
        check_eq("d4_settled", last_y, 8192);
        check_eq("d4_ready", status_ready, 1);

        // D=16 DC with compensation
        configure(4, 1'b1);
        check_eq("d16_d_active", status_D_active, 16);
        clear_stats(16);
        feed(256, 0, -16384);
        drain(10);
        check_eq("d16_count", yv_count, 16);
        check_eq("d16_period", bad_int, 0);
        check_eq("d16_settled", last_y, -16384);
        check_eq("d16_overflow", status_overflow, 0);

        // Ramp sweep over every legal sel, toggling compensation
        for (int s = 0; s <= 4; s++) begin
            configure(s, 1'(s % 2));
            check_eq($sformatf("ramp%0d_d_active", s), status_D_active, 1 << s);
            check_eq($sformatf("ramp%0d_ready_low", s), status_ready, 0);
            clear_stats(1 << s);
            feed(1024, 1, 0);
            drain(10);
            check_eq($sformatf("ramp%0d_count", s), yv_count, 1024 >> s);
            check_eq($sformatf("ramp%0d_period", s), bad_int, 0);
            check_eq($sformatf("ramp%0d_ready", s), status_ready, 1);
        end

        // D=2 compensated full-scale step overshoots Q1.15 range
        configure(1, 1'b1);
        ctrl_reset = 1'b1;
        tick();
        ctrl_reset = 1'b0;
        check_eq("step_ovf_cleared", status_overflow, 0);
        clear_stats(2);
        feed(64, 0, -32768);
        drain(8);
        check_eq("step_low", last_y, -32768);
        clear_stats(2);
        feed(64, 0, 32767);
        drain(8);
        check_eq("step_overshoot", (max_y > 32767) ? 1 : 0, 1);
        check_eq("step_high", last_y, 32767);
        drain(4);
        check_eq("step_ovf_sticky", status_overflow, 1);
        ctrl_reset = 1'b1;
        tick();
        ctrl_reset = 1'b0;
        tick();
        check_eq("step_ovf_after_clr", status_overflow, 0);
        check_eq("step_y_after_clr", y_out, 0);
        check_eq("step_ready_after_clr", status_ready, 0);

        // Illegal sel clamps to D=16; gapped input must complete a full window
        configure(7, 1'b1);
        check_eq("sel7_d_active", status_D_active, 16);
        check_eq("sel7_overflow", status_overflow, 2);
        clear_stats(0);
        for (int i = 0; i < 15; i++) begin
            x_valid = 1'b1;
            x_in    = 16'sd100;
            tick();
            x_valid = 1'b0;
            tick();
        end
        drain(10);
        check_eq("gap_no_output", yv_count, 0);
        check_eq("gap_no_ce", ce_count, 0);
        x_valid = 1'b1;
        tick();
        drain(10);
        check_eq("gap_one_output", yv_count, 1);
        check_eq("gap_one_ce", ce_count, 1);

        // ctrl_reset together with a valid sample drops the sample
        configure(0, 1'b0);
        clear_stats(0);
        ctrl_reset = 1'b1;
        x_valid    = 1'b1;
        x_in       = 16'sd1000;
        tick();
        ctrl_reset = 1'b0;
        drain(8);
        check_eq("rst_drop_output", yv_count, 0);
        check_eq("rst_drop_ovf", status_overflow, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
